// File: rtl/wfm_seq_ctrl_if.sv
// Command/status bundle between the USB-side command source and the waveform sequencer.
`timescale 1ns/1ps
interface wfm_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned THR_W  = 10
) ();
  logic [7:0]        cmd;
  logic              cmd_stb;
  logic              adc_stb;
  logic              xfer_rdy;
  logic [3:0]        mode;
  logic [ADDR_W-1:0] adrs;
  logic              mem_we;
  logic              mem_oe;
  logic              usb_we;
  logic [THR_W-1:0]  threshold;
  logic              busy;
  logic              wrapped;
  logic              done;

  modport master (
    output cmd, cmd_stb, adc_stb, xfer_rdy,
    input  mode, adrs, mem_we, mem_oe, usb_we, threshold, busy, wrapped, done
  );

  modport slave (
    input  cmd, cmd_stb, adc_stb, xfer_rdy,
    output mode, adrs, mem_we, mem_oe, usb_we, threshold, busy, wrapped, done
  );
endinterface

// File: rtl/wfm_seq_ctrl.sv
// Waveform memory command sequencer: decodes USB commands into datapath mode,
// drives the SRAM address counter/strobes and holds threshold and transfer length.
`timescale 1ns/1ps
module wfm_seq_ctrl #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned THR_W    = 10,
  parameter int unsigned THR_INIT = 512,
  parameter int unsigned LEN_DEF  = 128
) (
  input  logic          CLK,
  input  logic          RSTN,
  wfm_seq_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(LEN_DEF + 1);
  localparam logic [ADDR_W-1:0] ADRS_MAX = {ADDR_W{1'b1}};
  localparam logic [THR_W-1:0]  THR_MAX  = {THR_W{1'b1}};
  localparam logic [THR_W-1:0]  THR_RST  = THR_W'(THR_INIT);
  localparam logic [THR_W-1:0]  THR_BIG  = THR_W'(32);
  localparam logic [THR_W-1:0]  THR_SML  = THR_W'(4);
  localparam logic [LEN_W-1:0]  LEN_RST  = LEN_W'(LEN_DEF);

  localparam logic [7:0] CMD_CLEAR = 8'd1;
  localparam logic [7:0] CMD_RWND  = 8'd2;
  localparam logic [7:0] CMD_PATT  = 8'd3;
  localparam logic [7:0] CMD_IDLE  = 8'd4;
  localparam logic [7:0] CMD_XFER  = 8'd5;
  localparam logic [7:0] CMD_INIT  = 8'd6;
  localparam logic [7:0] CMD_ACQ   = 8'd7;
  localparam logic [7:0] CMD_LEN   = 8'd8;
  localparam logic [7:0] CMD_THUP  = 8'd16;
  localparam logic [7:0] CMD_THDN  = 8'd17;
  localparam logic [7:0] CMD_TFUP  = 8'd18;
  localparam logic [7:0] CMD_TFDN  = 8'd19;

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_CLEAR, S_PATTERN, S_XFER, S_INIT
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_oe_q, mem_oe_d;
  logic              usb_we_q, usb_we_d;
  logic [THR_W-1:0]  thr_q, thr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              wrapped_q, wrapped_d;
  logic              done_q, done_d;
  logic              busy_c;

  function automatic logic [3:0] mode_of(input state_e s);
    case (s)
      S_ACQ:     mode_of = 4'd7;
      S_CLEAR:   mode_of = 4'd1;
      S_PATTERN: mode_of = 4'd3;
      S_XFER:    mode_of = 4'd5;
      S_INIT:    mode_of = 4'd6;
      default:   mode_of = 4'd4;
    endcase
  endfunction

  function automatic logic is_busy(input state_e s);
    is_busy = (s == S_CLEAR) || (s == S_PATTERN) || (s == S_XFER);
  endfunction

  // One extra bit catches both overflow and borrow so the result clamps instead of wrapping.
  function automatic logic [THR_W-1:0] thr_step(input logic [THR_W-1:0] t,
                                                input logic up,
                                                input logic [THR_W-1:0] step);
    logic [THR_W:0] r;
    if (up) begin
      r = {1'b0, t} + {1'b0, step};
      thr_step = r[THR_W] ? THR_MAX : r[THR_W-1:0];
    end else begin
      r = {1'b0, t} - {1'b0, step};
      thr_step = r[THR_W] ? '0 : r[THR_W-1:0];
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    adrs_d    = adrs_q;
    mem_we_d  = 1'b0;
    mem_oe_d  = 1'b0;
    usb_we_d  = 1'b0;
    thr_d     = thr_q;
    len_d     = len_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;
    done_d    = 1'b0;
    busy_c    = is_busy(state_q);

    case (state_q)
      S_ACQ: begin
        mem_we_d = bus.adc_stb;
        if (mem_we_q) begin
          adrs_d = adrs_q + ADDR_W'(1);
          if (adrs_q == ADRS_MAX) wrapped_d = 1'b1;
        end
      end
      S_CLEAR, S_PATTERN: begin
        if (adrs_q == ADRS_MAX) begin
          adrs_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          adrs_d   = adrs_q + ADDR_W'(1);
          mem_we_d = 1'b1;
        end
      end
      S_XFER: begin
        // rem reaching zero means the final word is on usb_we this cycle.
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_oe_d = 1'b1;
          if (bus.xfer_rdy) begin
            usb_we_d = 1'b1;
            adrs_d   = adrs_q + ADDR_W'(1);
            rem_d    = rem_q - LEN_W'(1);
          end
        end
      end
      S_INIT:  state_d = S_IDLE;
      default: ;
    endcase

    if (bus.cmd_stb && (!busy_c || bus.cmd == CMD_IDLE)) begin
      case (bus.cmd)
        CMD_ACQ:   state_d = S_ACQ;
        CMD_CLEAR: begin
          state_d  = S_CLEAR;
          adrs_d   = '0;
          mem_we_d = 1'b1;
        end
        CMD_RWND: begin
          adrs_d    = '0;
          wrapped_d = 1'b0;
        end
        CMD_PATT: begin
          state_d  = S_PATTERN;
          adrs_d   = '0;
          mem_we_d = 1'b1;
        end
        CMD_IDLE: begin
          state_d  = S_IDLE;
          adrs_d   = '0;
          mem_we_d = 1'b0;
          mem_oe_d = 1'b0;
          usb_we_d = 1'b0;
          done_d   = 1'b0;
        end
        CMD_XFER: begin
          state_d  = S_XFER;
          mem_we_d = 1'b0;
          mem_oe_d = 1'b1;
          rem_d    = len_q;
        end
        CMD_INIT: begin
          state_d   = S_INIT;
          mem_we_d  = 1'b0;
          thr_d     = THR_RST;
          len_d     = LEN_RST;
          adrs_d    = '0;
          wrapped_d = 1'b0;
        end
        CMD_LEN:  len_d = LEN_RST;
        CMD_THUP: thr_d = thr_step(thr_q, 1'b1, THR_BIG);
        CMD_THDN: thr_d = thr_step(thr_q, 1'b0, THR_BIG);
        CMD_TFUP: thr_d = thr_step(thr_q, 1'b1, THR_SML);
        CMD_TFDN: thr_d = thr_step(thr_q, 1'b0, THR_SML);
        default: ;
      endcase
    end

    mode_d = mode_of(state_d);
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      mode_q    <= 4'd4;
      adrs_q    <= '0;
      mem_we_q  <= 1'b0;
      mem_oe_q  <= 1'b0;
      usb_we_q  <= 1'b0;
      thr_q     <= THR_RST;
      len_q     <= LEN_RST;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      adrs_q    <= adrs_d;
      mem_we_q  <= mem_we_d;
      mem_oe_q  <= mem_oe_d;
      usb_we_q  <= usb_we_d;
      thr_q     <= thr_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.adrs      = adrs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.usb_we    = usb_we_q;
  assign bus.threshold = thr_q;
  assign bus.busy      = busy_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_wfm_seq_ctrl.sv
// Directed bench for wfm_seq_ctrl with a 4-bit address counter so full sweeps stay short.
`timescale 1ns/1ps
module tb_wfm_seq_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned TW = 10;

  logic CLK;
  logic RSTN;
  int   n_chk;
  int   n_pass;

  wfm_seq_ctrl_if #(.ADDR_W(AW), .THR_W(TW)) bus ();

  wfm_seq_ctrl #(
    .ADDR_W(AW), .THR_W(TW), .THR_INIT(512), .LEN_DEF(128)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called at a falling edge; the command is sampled at the next rising edge.
  task automatic send_cmd(input logic [7:0] c);
    bus.cmd     = c;
    bus.cmd_stb = 1'b1;
    @(negedge CLK);
    bus.cmd_stb = 1'b0;
    bus.cmd     = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we_cnt, done_cnt, adrs_bad, usb_cnt, bad_we, bad_oe, done_at;
    logic prev_rdy;
    n_chk = 0;
    n_pass = 0;
    RSTN = 1'b0;
    bus.cmd = 8'd0;
    bus.cmd_stb = 1'b0;
    bus.adc_stb = 1'b0;
    bus.xfer_rdy = 1'b0;
    repeat (2) @(negedge CLK);

    check("rst_mode", 32'(bus.mode), 4);
    check("rst_adrs", 32'(bus.adrs), 0);
    check("rst_strobes", {29'd0, bus.mem_we, bus.mem_oe, bus.usb_we}, 0);
    check("rst_flags", {29'd0, bus.busy, bus.wrapped, bus.done}, 0);
    check("rst_thr", 32'(bus.threshold), 512);
    RSTN = 1'b1;
    @(negedge CLK);

    // Threshold saturation in both directions and the fine steps
    repeat (20) send_cmd(8'd16);
    check("thr_sat_hi", 32'(bus.threshold), 1023);
    check("thr_mode", 32'(bus.mode), 4);
    send_cmd(8'd6);
    check("init_mode", 32'(bus.mode), 6);
    check("init_thr", 32'(bus.threshold), 512);
    @(negedge CLK);
    check("init_to_idle", 32'(bus.mode), 4);
    repeat (3) send_cmd(8'd19);
    check("thr_fine_dn", 32'(bus.threshold), 500);
    send_cmd(8'd18);
    check("thr_fine_up", 32'(bus.threshold), 504);
    repeat (20) send_cmd(8'd17);
    check("thr_sat_lo", 32'(bus.threshold), 0);
    send_cmd(8'd6);
    @(negedge CLK);
    send_cmd(8'd9);
    send_cmd(8'd8);
    check("unknown_ignored", {bus.mode, 22'd0, bus.threshold}, {4'd4, 22'd0, 10'd512});

    // CLEAR sweeps every address once, then one done pulse
    send_cmd(8'd1);
    check("clear_mode", 32'(bus.mode), 1);
    check("clear_busy", 32'(bus.busy), 1);
    we_cnt = 0; done_cnt = 0; adrs_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_we) begin
        if (32'(bus.adrs) != 32'(we_cnt)) adrs_bad++;
        we_cnt++;
      end
      if (bus.done) done_cnt++;
      @(negedge CLK);
    end
    check("clear_writes", 32'(we_cnt), 16);
    check("clear_adrs_seq", 32'(adrs_bad), 0);
    check("clear_done", 32'(done_cnt), 1);
    check("clear_end", {bus.mode, 3'd0, bus.busy, 4'd0, 16'd0, 4'(bus.adrs)}, {4'd4, 28'd0});

    // ACQ: 20 samples into a 16-entry space wraps once
    send_cmd(8'd7);
    check("acq_mode", 32'(bus.mode), 7);
    we_cnt = 0; adrs_bad = 0;
    for (int k = 0; k < 20; k++) begin
      bus.adc_stb = 1'b1;
      @(negedge CLK);
      bus.adc_stb = 1'b0;
      if (bus.mem_we) begin
        if (32'(bus.adrs) != 32'(k % 16)) adrs_bad++;
        we_cnt++;
      end
      @(negedge CLK);
      if (k == 14) begin
        check("acq_pre_wrap_adrs", 32'(bus.adrs), 15);
        check("acq_pre_wrap_flag", 32'(bus.wrapped), 0);
      end
    end
    check("acq_writes", 32'(we_cnt), 20);
    check("acq_adrs_seq", 32'(adrs_bad), 0);
    check("acq_adrs", 32'(bus.adrs), 4);
    check("acq_wrapped", 32'(bus.wrapped), 1);
    check("acq_idle_we", 32'(bus.mem_we), 0);
    send_cmd(8'd2);
    check("rewind", {bus.mode, 23'd0, bus.wrapped, 4'(bus.adrs)}, {4'd7, 28'd0});
    repeat (3) begin
      bus.adc_stb = 1'b1;
      @(negedge CLK);
      bus.adc_stb = 1'b0;
      @(negedge CLK);
    end
    check("acq_adrs3", 32'(bus.adrs), 3);

    // XFER with xfer_rdy alternating: 128 words over 256 cycles
    send_cmd(8'd5);
    check("xfer_mode", 32'(bus.mode), 5);
    check("xfer_start", {29'd0, bus.busy, bus.mem_oe, bus.usb_we}, 6);
    usb_cnt = 0; done_cnt = 0; bad_we = 0; bad_oe = 0; done_at = -1;
    prev_rdy = 1'b0;
    for (int i = 0; i < 280; i++) begin
      if (bus.usb_we) begin
        usb_cnt++;
        if (!prev_rdy) bad_we++;
      end
      if (bus.mode == 4'd5 && !bus.mem_oe) bad_oe++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      prev_rdy = ((i % 2) == 0);
      bus.xfer_rdy = prev_rdy;
      @(negedge CLK);
    end
    bus.xfer_rdy = 1'b0;
    check("xfer_words", 32'(usb_cnt), 128);
    check("xfer_stall", 32'(bad_we), 0);
    check("xfer_oe", 32'(bad_oe), 0);
    check("xfer_done_cnt", 32'(done_cnt), 1);
    check("xfer_done_at", 32'(done_at), 256);
    check("xfer_adrs", 32'(bus.adrs), 3);
    check("xfer_end", {bus.mode, 26'd0, bus.busy, bus.mem_oe}, {4'd4, 28'd0});

    // PATTERN ignores everything but abort; abort gives no done
    send_cmd(8'd3);
    check("patt_start", {bus.mode, 26'd0, bus.busy, bus.mem_we}, {4'd3, 28'd3});
    check("patt_adrs0", 32'(bus.adrs), 0);
    send_cmd(8'd7);
    check("patt_ign_acq", 32'(bus.mode), 3);
    send_cmd(8'd16);
    check("patt_ign_thr", 32'(bus.threshold), 512);
    check("patt_adrs2", 32'(bus.adrs), 2);
    send_cmd(8'd4);
    check("abort_mode", 32'(bus.mode), 4);
    check("abort_adrs", 32'(bus.adrs), 0);
    check("abort_flags", {29'd0, bus.busy, bus.mem_we, bus.done}, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) done_cnt++;
      @(negedge CLK);
    end
    check("abort_no_done", 32'(done_cnt), 0);

    // Asynchronous reset in the middle of a transfer
    send_cmd(8'd16);
    check("thr_pre_rst", 32'(bus.threshold), 544);
    bus.xfer_rdy = 1'b1;
    send_cmd(8'd5);
    repeat (5) @(negedge CLK);
    check("xfer_run_adrs", 32'(bus.adrs), 5);
    check("xfer_run_we", {30'd0, bus.busy, bus.usb_we}, 3);
    #2 RSTN = 1'b0;
    #1;
    check("arst_mode", 32'(bus.mode), 4);
    check("arst_adrs", 32'(bus.adrs), 0);
    check("arst_strobes", {29'd0, bus.mem_we, bus.mem_oe, bus.usb_we}, 0);
    check("arst_flags", {29'd0, bus.busy, bus.wrapped, bus.done}, 0);
    check("arst_thr", 32'(bus.threshold), 512);
    bus.xfer_rdy = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
